lsu_ctrl: RTL and testbench

Load/store unit sitting directly downstream of the ALU in the EX→MEM path. It takes the ALU-computed effective address (`alu_result`), the store operand (`read_data2`) and `funct3`, and runs a multi-cycle req/gnt/rvalid transaction to data memory. It generates byte enables, aligns load data, and sign- or zero-extends it. It stalls the core while a transaction is outstanding.

---
 rtl/lsu_ctrl_if.sv | 29 ++
 rtl/lsu_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_ctrl_if.sv
// Data-memory bus between the load/store unit (master) and data memory (slave).
// req/gnt accepts a request; rvalid returns read data at least one cycle after gnt.
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif
`ifndef FUNCT3_WIDTH
`define FUNCT3_WIDTH 3
`endif

interface lsu_ctrl_if;
   logic                       dmem_req;
   logic                       dmem_we;
   logic [`REG_DATA_WIDTH-1:0] dmem_addr;
   logic [3:0]                 dmem_be;
   logic [`REG_DATA_WIDTH-1:0] dmem_wdata;
   logic                       dmem_gnt;
   logic                       dmem_rvalid;
   logic [`REG_DATA_WIDTH-1:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      input  dmem_gnt, dmem_rvalid, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      output dmem_gnt, dmem_rvalid, dmem_rdata
   );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store unit: runs one req/gnt/rvalid data-memory access per memory
// instruction, builds byte enables, aligns and extends load data, stalls the core.
//
// state  | meaning
// IDLE   | waiting for a memory instruction; illegal/misaligned ones go straight to DONE
// REQ    | dmem_req held with stable addr/be/wdata until gnt
// WAIT   | load granted, waiting for rvalid
// DONE   | one-cycle completion pulse, lsu_err valid
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif
`ifndef FUNCT3_WIDTH
`define FUNCT3_WIDTH 3
`endif

module lsu_ctrl #(
   parameter int WAIT_LIMIT = 255
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       mem_start,
   input  logic                       memread,
   input  logic                       memwrite,
   input  logic [`FUNCT3_WIDTH-1:0]   funct3,
   input  logic [`REG_DATA_WIDTH-1:0] addr,
   input  logic [`REG_DATA_WIDTH-1:0] store_data,
   output logic                       lsu_busy,
   output logic                       lsu_done,
   output logic                       lsu_err,
   output logic [`REG_DATA_WIDTH-1:0] load_data,
   lsu_ctrl_if.master                 dmem
);

   localparam int DW = `REG_DATA_WIDTH;
   localparam int CW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
   localparam logic [CW-1:0] LIM_M1 = CW'((WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

   state_t        state, state_n;
   logic          accept, bad, f3_legal, misal, timeout, err_set;
   logic [3:0]    be_n;
   logic [DW-1:0] wdata_n;
   logic [CW-1:0] cnt;
   logic [1:0]    off_q;
   logic [2:0]    f3_q;
   logic          we_q, err_q;
   logic [DW-1:0] addr_q, wdata_q;
   logic [3:0]    be_q;
   logic [7:0]    lane_b;
   logic [15:0]   lane_h;
   logic [DW-1:0] ext;

   assign accept = (state == S_IDLE) && mem_start && (memread || memwrite);

   always_comb begin
      f3_legal = 1'b0;
      case (funct3)
         3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
         3'b100, 3'b101:         f3_legal = memread;
         default:                f3_legal = 1'b0;
      endcase
      misal = ((funct3[1:0] == 2'b01) && addr[0]) ||
              ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
      bad   = !f3_legal || misal;
      case (funct3[1:0])
         2'b00: begin
            be_n    = 4'b0001 << addr[1:0];
            wdata_n = {4{store_data[7:0]}};
         end
         2'b01: begin
            be_n    = 4'b0011 << {addr[1], 1'b0};
            wdata_n = {2{store_data[15:0]}};
         end
         default: begin
            be_n    = 4'b1111;
            wdata_n = store_data;
         end
      endcase
   end

   // A load granted on the last allowed cycle still times out in WAIT, hence >=.
   assign timeout = (WAIT_LIMIT != 0) && (cnt >= LIM_M1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      err_set = 1'b0;
      case (state)
         S_IDLE: begin
            if (accept) begin
               state_n = bad ? S_DONE : S_REQ;
               err_set = bad;
            end
         end
         S_REQ: begin
            if (dmem.dmem_gnt) begin
               state_n = we_q ? S_DONE : S_WAIT;
            end else if (timeout) begin
               state_n = S_DONE;
               err_set = 1'b1;
            end
         end
         S_WAIT: begin
            if (dmem.dmem_rvalid) begin
               state_n = S_DONE;
            end else if (timeout) begin
               state_n = S_DONE;
               err_set = 1'b1;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_comb begin
      lsu_busy      = 1'b0;
      lsu_done      = 1'b0;
      dmem.dmem_req = 1'b0;
      dmem.dmem_we  = 1'b0;
      case (state)
         S_IDLE: lsu_busy = accept;
         S_REQ: begin
            lsu_busy      = 1'b1;
            dmem.dmem_req = 1'b1;
            dmem.dmem_we  = we_q;
         end
         S_WAIT:  lsu_busy = 1'b1;
         default: lsu_done = 1'b1;
      endcase
   end

   assign dmem.dmem_addr  = addr_q;
   assign dmem.dmem_be    = be_q;
   assign dmem.dmem_wdata = wdata_q;
   assign lsu_err         = err_q;

   always_comb begin
      case (off_q)
         2'd0:    lane_b = dmem.dmem_rdata[7:0];
         2'd1:    lane_b = dmem.dmem_rdata[15:8];
         2'd2:    lane_b = dmem.dmem_rdata[23:16];
         default: lane_b = dmem.dmem_rdata[31:24];
      endcase
      lane_h = off_q[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
      case (f3_q)
         3'b000:  ext = {{(DW-8){lane_b[7]}}, lane_b};
         3'b001:  ext = {{(DW-16){lane_h[15]}}, lane_h};
         3'b100:  ext = {{(DW-8){1'b0}}, lane_b};
         3'b101:  ext = {{(DW-16){1'b0}}, lane_h};
         default: ext = dmem.dmem_rdata;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         off_q     <= '0;
         f3_q      <= '0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         be_q      <= '0;
         wdata_q   <= '0;
         err_q     <= 1'b0;
         cnt       <= '0;
         load_data <= '0;
      end else begin
         err_q <= err_set;
         if (accept) begin
            off_q   <= addr[1:0];
            f3_q    <= funct3;
            we_q    <= !memread;
            addr_q  <= {addr[DW-1:2], 2'b00};
            be_q    <= be_n;
            wdata_q <= wdata_n;
         end
         if (accept && !bad)
            cnt <= '0;
         else if (state == S_REQ || state == S_WAIT)
            cnt <= cnt + 1'b1;
         if (state == S_WAIT && dmem.dmem_rvalid)
            load_data <= ext;
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: expected completions are queued at issue and
// popped when lsu_done pulses; a second instance with WAIT_LIMIT=4 covers timeout.
module tb_lsu_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_start, mem_start2, memread, memwrite;
   logic [2:0]  funct3;
   logic [31:0] addr, store_data;
   logic        lsu_busy, lsu_done, lsu_err;
   logic [31:0] load_data;
   logic        lsu_busy2, lsu_done2, lsu_err2;
   logic [31:0] load_data2;

   lsu_ctrl_if mif ();
   lsu_ctrl_if mif2 ();

   typedef struct {
      logic        err;
      logic [31:0] data;
      int          lat;
      int          start;
   } exp_t;

   exp_t exp_q[$];
   int   ncmp = 0;
   int   nerr = 0;
   int   cyc_cnt = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   lsu_ctrl u_dut (
      .clk(clk), .rst(rst), .mem_start(mem_start), .memread(memread),
      .memwrite(memwrite), .funct3(funct3), .addr(addr), .store_data(store_data),
      .lsu_busy(lsu_busy), .lsu_done(lsu_done), .lsu_err(lsu_err),
      .load_data(load_data), .dmem(mif)
   );

   lsu_ctrl #(.WAIT_LIMIT(4)) u_dut_to (
      .clk(clk), .rst(rst), .mem_start(mem_start2), .memread(memread),
      .memwrite(memwrite), .funct3(funct3), .addr(addr), .store_data(store_data),
      .lsu_busy(lsu_busy2), .lsu_done(lsu_done2), .lsu_err(lsu_err2),
      .load_data(load_data2), .dmem(mif2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd,
                        input logic e_err, input logic [31:0] e_data, input int e_lat);
      exp_t e;
      mem_start  = 1'b1;
      memread    = rd;
      memwrite   = wr;
      funct3     = f3;
      addr       = a;
      store_data = sd;
      e.err   = e_err;
      e.data  = e_data;
      e.lat   = e_lat;
      e.start = cyc_cnt;
      exp_q.push_back(e);
   endtask

   task automatic release_in();
      mem_start = 1'b0;
      memread   = 1'b0;
      memwrite  = 1'b0;
   endtask

   // Returns at mid-cycle of the DONE cycle (or after the budget expires).
   task automatic expect_done(input string tag, input int max_cyc);
      exp_t e;
      bit   seen;
      seen = 1'b0;
      for (int n = 0; n < max_cyc; n++) begin
         mid();
         if (lsu_done) begin
            seen = 1'b1;
            break;
         end
         cyc();
      end
      chk({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
      if (exp_q.size() == 0) begin
         chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         chk({tag, "_err"}, {31'd0, lsu_err}, {31'd0, e.err});
         chk({tag, "_data"}, load_data, e.data);
         chk({tag, "_latency"}, cyc_cnt - e.start, e.lat);
      end
   endtask

   initial begin
      int n;
      rst = 1'b1;
      mem_start = 1'b0; mem_start2 = 1'b0; memread = 1'b0; memwrite = 1'b0;
      funct3 = 3'b000; addr = '0; store_data = '0;
      mif.dmem_gnt = 1'b0;  mif.dmem_rvalid = 1'b0;  mif.dmem_rdata = '0;
      mif2.dmem_gnt = 1'b0; mif2.dmem_rvalid = 1'b0; mif2.dmem_rdata = '0;

      // reset values
      mid();
      chk("rst_busy", {31'd0, lsu_busy}, 32'd0);
      chk("rst_done", {31'd0, lsu_done}, 32'd0);
      chk("rst_err", {31'd0, lsu_err}, 32'd0);
      chk("rst_ld", load_data, 32'd0);
      chk("rst_req", {31'd0, mif.dmem_req}, 32'd0);
      chk("rst_addr", mif.dmem_addr, 32'd0);
      chk("rst_be", {28'd0, mif.dmem_be}, 32'd0);
      cyc();
      rst = 1'b0;
      cyc();

      // lb sign-extend at 0x1003
      issue(1'b1, 1'b0, 3'b000, 32'h1003, 32'h0, 1'b0, 32'hFFFF_FF80, 3);
      mid();
      chk("lb_busy_accept", {31'd0, lsu_busy}, 32'd1);
      chk("lb_req_c0", {31'd0, mif.dmem_req}, 32'd0);
      cyc();
      release_in();
      mif.dmem_gnt = 1'b1;
      mid();
      chk("lb_req", {31'd0, mif.dmem_req}, 32'd1);
      chk("lb_we", {31'd0, mif.dmem_we}, 32'd0);
      chk("lb_addr", mif.dmem_addr, 32'h1000);
      chk("lb_be", {28'd0, mif.dmem_be}, 32'h8);
      cyc();
      mif.dmem_gnt = 1'b0;
      mif.dmem_rvalid = 1'b1;
      mif.dmem_rdata = 32'h80AB_CDEF;
      mid();
      chk("lb_wait_req", {31'd0, mif.dmem_req}, 32'd0);
      chk("lb_wait_busy", {31'd0, lsu_busy}, 32'd1);
      cyc();
      mif.dmem_rvalid = 1'b0;
      expect_done("lb", 6);
      chk("lb_done_busy", {31'd0, lsu_busy}, 32'd0);
      cyc();

      // sh at 0x2002
      issue(1'b0, 1'b1, 3'b001, 32'h2002, 32'h1234_BEEF, 1'b0, 32'hFFFF_FF80, 2);
      cyc();
      release_in();
      mif.dmem_gnt = 1'b1;
      mid();
      chk("sh_req", {31'd0, mif.dmem_req}, 32'd1);
      chk("sh_we", {31'd0, mif.dmem_we}, 32'd1);
      chk("sh_addr", mif.dmem_addr, 32'h2000);
      chk("sh_be", {28'd0, mif.dmem_be}, 32'hC);
      chk("sh_wdata", mif.dmem_wdata, 32'hBEEF_BEEF);
      cyc();
      mif.dmem_gnt = 1'b0;
      expect_done("sh", 6);
      cyc();

      // lhu at 0x2002
      issue(1'b1, 1'b0, 3'b101, 32'h2002, 32'h0, 1'b0, 32'h0000_BEEF, 3);
      cyc();
      release_in();
      mif.dmem_gnt = 1'b1;
      mid();
      chk("lhu_be", {28'd0, mif.dmem_be}, 32'hC);
      chk("lhu_we", {31'd0, mif.dmem_we}, 32'd0);
      cyc();
      mif.dmem_gnt = 1'b0;
      mif.dmem_rvalid = 1'b1;
      mif.dmem_rdata = 32'hBEEF_0000;
      cyc();
      mif.dmem_rvalid = 1'b0;
      expect_done("lhu", 6);
      cyc();

      // misaligned lw at 0x3001
      issue(1'b1, 1'b0, 3'b010, 32'h3001, 32'h0, 1'b1, 32'h0000_BEEF, 1);
      mid();
      chk("misal_busy_accept", {31'd0, lsu_busy}, 32'd1);
      cyc();
      release_in();
      expect_done("misal", 4);
      chk("misal_no_req", {31'd0, mif.dmem_req}, 32'd0);
      cyc();
      mid();
      chk("misal_err_cleared", {31'd0, lsu_err}, 32'd0);
      chk("misal_done_cleared", {31'd0, lsu_done}, 32'd0);
      cyc();

      // illegal store funct3 100
      issue(1'b0, 1'b1, 3'b100, 32'h3000, 32'h55, 1'b1, 32'h0000_BEEF, 1);
      cyc();
      release_in();
      expect_done("ill_st", 4);
      chk("ill_st_no_req", {31'd0, mif.dmem_req}, 32'd0);
      cyc();

      // sw with gnt withheld 5 cycles
      issue(1'b0, 1'b1, 3'b010, 32'h4000, 32'hCAFE_F00D, 1'b0, 32'h0000_BEEF, 7);
      cyc();
      release_in();
      for (int i = 0; i < 5; i++) begin
         mid();
         chk("held_req", {31'd0, mif.dmem_req}, 32'd1);
         chk("held_addr", mif.dmem_addr, 32'h4000);
         chk("held_be", {28'd0, mif.dmem_be}, 32'hF);
         chk("held_busy", {31'd0, lsu_busy}, 32'd1);
         cyc();
      end
      mif.dmem_gnt = 1'b1;
      mid();
      chk("held_wdata", mif.dmem_wdata, 32'hCAFE_F00D);
      cyc();
      mif.dmem_gnt = 1'b0;
      expect_done("held", 6);
      cyc();

      // timeout on the WAIT_LIMIT=4 instance, gnt never given
      mem_start2 = 1'b1;
      memread = 1'b1;
      funct3 = 3'b010;
      addr = 32'h5000;
      n = 0;
      cyc();
      mem_start2 = 1'b0;
      memread = 1'b0;
      n = 1;
      while (n < 12) begin
         mid();
         if (lsu_done2) break;
         chk("to_busy", {31'd0, lsu_busy2}, 32'd1);
         cyc();
         n++;
      end
      chk("to_latency", n, 32'd5);
      chk("to_done", {31'd0, lsu_done2}, 32'd1);
      chk("to_err", {31'd0, lsu_err2}, 32'd1);
      chk("to_ld", load_data2, 32'd0);
      chk("to_busy_done", {31'd0, lsu_busy2}, 32'd0);
      cyc();
      mid();
      chk("to_idle_busy", {31'd0, lsu_busy2}, 32'd0);
      chk("to_idle_done", {31'd0, lsu_done2}, 32'd0);
      chk("to_idle_err", {31'd0, lsu_err2}, 32'd0);
      cyc();

      // reset asserted while in WAIT
      mem_start = 1'b1; memread = 1'b1; funct3 = 3'b100; addr = 32'h6001;
      cyc();
      release_in();
      mif.dmem_gnt = 1'b1;
      cyc();
      mif.dmem_gnt = 1'b0;
      mid();
      chk("rw_wait_busy", {31'd0, lsu_busy}, 32'd1);
      #1;
      rst = 1'b1;
      #1;
      chk("rw_busy", {31'd0, lsu_busy}, 32'd0);
      chk("rw_req", {31'd0, mif.dmem_req}, 32'd0);
      chk("rw_ld", load_data, 32'd0);
      chk("rw_addr", mif.dmem_addr, 32'd0);
      chk("rw_be", {28'd0, mif.dmem_be}, 32'd0);
      cyc();
      rst = 1'b0;
      mif.dmem_rvalid = 1'b1;
      mif.dmem_gnt = 1'b1;
      mif.dmem_rdata = 32'hFFFF_FFFF;
      cyc();
      mif.dmem_rvalid = 1'b0;
      mif.dmem_gnt = 1'b0;
      for (int i = 0; i < 3; i++) begin
         mid();
         chk("rw_late_done", {31'd0, lsu_done}, 32'd0);
         chk("rw_late_ld", load_data, 32'd0);
         cyc();
      end

      // lb positive byte after reset
      issue(1'b1, 1'b0, 3'b000, 32'h7001, 32'h0, 1'b0, 32'h0000_007F, 3);
      cyc();
      release_in();
      mif.dmem_gnt = 1'b1;
      mid();
      chk("lbp_be", {28'd0, mif.dmem_be}, 32'h2);
      cyc();
      mif.dmem_gnt = 1'b0;
      mif.dmem_rvalid = 1'b1;
      mif.dmem_rdata = 32'h0000_7F00;
      cyc();
      mif.dmem_rvalid = 1'b0;
      expect_done("lbp", 6);
      cyc();

      chk("sb_drained", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
